alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
ID/EX operand stage directly upstream of the 32-bit ALU. It registers decoded instruction fields and resolves register hazards by forwarding from the MEM and WB stages. It selects the shamt or immediate sources and presents a, b and op to the ALU through a 2-entry skid buffer with a valid/ready handshake. A flush input lets branch and exception logic squash in-flight operands.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32)
RA_W, 5, register-file address width
DEPTH, 2, skid-buffer entries (fixed at 2; count is 2 bits)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  decoder presents an instruction
in_ready_o  out  1  stage accepts; transfer when in_valid_i & in_ready_o
rs_addr_i  in  RA_W  source A register address
rs_data_i  in  DATA_W  register-file value for rs
rt_addr_i  in  RA_W  source B register address
rt_data_i  in  DATA_W  register-file value for rt
imm_i  in  DATA_W  extended immediate
shamt_i  in  5  shift amount field
src_a_sel_i  in  1  0: A=rs (forwarded); 1: A=zero-extended shamt_i
src_b_sel_i  in  1  0: B=rt (forwarded); 1: B=imm_i
alu_op_i  in  4  ALU op code, passed through unchanged
rd_addr_i  in  RA_W  destination register
mem_we_i, mem_addr_i, mem_data_i  in  1/RA_W/DATA_W  MEM-stage pending write
wb_we_i, wb_addr_i, wb_data_i  in  1/RA_W/DATA_W  WB-stage pending write
flush_i  in  1  squash all held and incoming entries
out_valid_o  out  1  head entry valid for ALU
out_ready_i  in  1  downstream consumes head
a_o  out  DATA_W  ALU operand A
b_o  out  DATA_W  ALU operand B
op_o  out  4  ALU op
rd_addr_o  out  RA_W  destination register of the head entry

Behaviour:
- Reset (rst_ni low, asynchronous): count=0, rd/wr pointers=0, all entry fields=0. Outputs: out_valid_o=0, a_o=b_o=0, op_o=0, rd_addr_o=0, in_ready_o=1.
- Storage: 2-entry circular FIFO. Each entry holds a, b, op, rd, rs_addr, rt_addr, a_is_reg, b_is_reg.
- in_ready_o = (count != 2), combinational from registered count only; no combinational path from out_ready_i.
- out_valid_o = (count != 0). a_o, b_o, op_o and rd_addr_o always reflect the head entry, and are 0 when empty.
- Latency: an entry accepted at edge N is presented at out_valid_o after edge N. Minimum 1 cycle; throughput 1 per cycle.
- Forward function fwd(addr, regval): if addr==0, result 0 (r0 is never forwarded). Else if mem_we_i & mem_addr_i==addr, result mem_data_i. Else if wb_we_i & wb_addr_i==addr, result wb_data_i. Else result regval. MEM has priority over WB.
- Capture: a = src_a_sel_i ? {27'b0, shamt_i} : fwd(rs_addr_i, rs_data_i); a_is_reg = ~src_a_sel_i. b = src_b_sel_i ? imm_i : fwd(rt_addr_i, rt_data_i); b_is_reg = ~src_b_sel_i.
- Snoop: every cycle, each held valid entry not popped this cycle updates a and/or b using fwd(stored addr, stored value), only where the field's is_reg flag is set. Write addr 0 never updates.
- Push and pop in the same cycle are both legal when 0 < count < 2; count is unchanged.
- Full (count=2): no push; a pop frees a slot, but in_ready_o rises only on the next cycle.
- Empty: out_ready_i is ignored and no pop occurs.
- Pointer wrap: pointers are 1 bit and toggle modulo 2.
- Flush: flush_i high at an edge sets count=0 and resets the pointers. Any same-cycle push is dropped and no pop is counted. out_valid_o=0 the next cycle. flush_i has priority over push, pop and snoop.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.

Test Plan:
- Basic pass: rs=3 (0x10), rt=4 (0x5), op=0010, sels=0, no forwarding, out_ready_i=1 -> next cycle out_valid_o=1, a_o=0x10, b_o=0x5, op_o=0010.
- Forwarding priority: rs=7 with rs_data=0x1; mem writes r7=0xAA and wb writes r7=0xBB in the same cycle -> a_o=0xAA. Repeat with mem_we_i=0 -> a_o=0xBB. Repeat with rs=0 and both ports writing r0 -> a_o=0.
- Snoop while held: out_ready_i=0, entry with rt=9 (0x0) held; 2 cycles later wb writes r9=0x1234 -> b_o=0x1234. Entry with src_b_sel=1 and imm=0x8 is unchanged by the same write.
- Full/backpressure: out_ready_i=0, push 3 back-to-back -> in_ready_o=0 after 2 accepts and the 3rd is held by the source. Then out_ready_i=1 -> entries appear in order, no loss or duplication.
- Flush: count=2 plus flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, count=0, incoming entry dropped, in_ready_o=1.
- Async reset: deassert rst_ni mid-stream, between clock edges -> out_valid_o=0 and a_o=b_o=0 immediately. After release, the first push appears 1 cycle later.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX operand stage feeding the 32-bit ALU.
// Captures decoded fields, forwards pending MEM/WB writes (MEM wins, r0 never
// forwarded), selects shamt/immediate sources, and holds the resulting
// operands in a 2-entry circular skid buffer. Held entries keep snooping the
// MEM/WB write ports so their register-sourced operands stay current.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o    decoder handshake; in_ready_o depends on count only
//   rs_*, rt_*, imm_i,
//   shamt_i, src_*_sel_i     operand sources and selects
//   alu_op_i, rd_addr_i      passed through with the entry
//   mem_*, wb_*              pending register writes used for forwarding
//   flush_i                  squash held and incoming entries
//   out_valid_o/out_ready_i  ALU handshake
//   a_o, b_o, op_o,
//   rd_addr_o                head entry fields (zero when empty)

package alu_operand_stage_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned OP_W   = 4;

    // One buffered operand set; rs/rt and the is_reg flags drive snooping.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic              a_is_reg;
        logic              b_is_reg;
    } entry_t;
endpackage

module alu_operand_stage #(
    parameter int unsigned DATA_W = alu_operand_stage_pkg::DATA_W,
    parameter int unsigned RA_W   = alu_operand_stage_pkg::RA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [RA_W-1:0]   rs_addr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [RA_W-1:0]   rt_addr_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        shamt_i,
    input  logic              src_a_sel_i,
    input  logic              src_b_sel_i,
    input  logic [3:0]        alu_op_i,
    input  logic [RA_W-1:0]   rd_addr_i,
    input  logic              mem_we_i,
    input  logic [RA_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_we_i,
    input  logic [RA_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [3:0]        op_o,
    output logic [RA_W-1:0]   rd_addr_o
);
    import alu_operand_stage_pkg::entry_t;

    localparam int unsigned CNT_W = 2;

    entry_t             mem_q   [2];
    entry_t             mem_nxt [2];
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic               wr_ptr_q, wr_ptr_nxt;
    logic               rd_ptr_q, rd_ptr_nxt;
    logic               push, pop;
    entry_t             cap;

    // Forwarding mux: r0 reads as zero, MEM beats WB, else register file value.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [RA_W-1:0]   addr,
        input logic [DATA_W-1:0] regval,
        input logic              m_we,
        input logic [RA_W-1:0]   m_addr,
        input logic [DATA_W-1:0] m_data,
        input logic              w_we,
        input logic [RA_W-1:0]   w_addr,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] res;
        if (addr == '0)                      res = '0;
        else if (m_we && (m_addr == addr))   res = m_data;
        else if (w_we && (w_addr == addr))   res = w_data;
        else                                 res = regval;
        return res;
    endfunction

    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_ready_i & out_valid_o;

    // Head entry presented to the ALU, forced to zero when empty.
    assign a_o       = out_valid_o ? mem_q[rd_ptr_q].a  : '0;
    assign b_o       = out_valid_o ? mem_q[rd_ptr_q].b  : '0;
    assign op_o      = out_valid_o ? mem_q[rd_ptr_q].op : '0;
    assign rd_addr_o = out_valid_o ? mem_q[rd_ptr_q].rd : '0;

    // Build the incoming entry from the decoder fields.
    always_comb begin
        cap          = '0;
        cap.a        = src_a_sel_i ? DATA_W'(shamt_i)
                                   : fwd(rs_addr_i, rs_data_i, mem_we_i, mem_addr_i,
                                         mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
        cap.b        = src_b_sel_i ? imm_i
                                   : fwd(rt_addr_i, rt_data_i, mem_we_i, mem_addr_i,
                                         mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
        cap.op       = alu_op_i;
        cap.rd       = rd_addr_i;
        cap.rs       = rs_addr_i;
        cap.rt       = rt_addr_i;
        cap.a_is_reg = ~src_a_sel_i;
        cap.b_is_reg = ~src_b_sel_i;
    end

    // Next-state: flush wins; otherwise snoop held entries, then push/pop.
    always_comb begin
        mem_nxt    = mem_q;
        count_nxt  = count_q;
        wr_ptr_nxt = wr_ptr_q;
        rd_ptr_nxt = rd_ptr_q;
        if (flush_i) begin
            count_nxt  = '0;
            wr_ptr_nxt = 1'b0;
            rd_ptr_nxt = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                // Slot is live when full, or when it is the sole head entry.
                if (((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i))))
                    && !(pop && (rd_ptr_q == 1'(i)))) begin
                    if (mem_q[i].a_is_reg)
                        mem_nxt[i].a = fwd(mem_q[i].rs, mem_q[i].a, mem_we_i, mem_addr_i,
                                           mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
                    if (mem_q[i].b_is_reg)
                        mem_nxt[i].b = fwd(mem_q[i].rt, mem_q[i].b, mem_we_i, mem_addr_i,
                                           mem_data_i, wb_we_i, wb_addr_i, wb_data_i);
                end
            end
            if (push) begin
                mem_nxt[wr_ptr_q] = cap;
                wr_ptr_nxt        = ~wr_ptr_q;
            end
            if (pop) rd_ptr_nxt = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_nxt = count_q + 2'd1;
                2'b01:   count_nxt = count_q - 2'd1;
                default: count_nxt = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            count_q  <= count_nxt;
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            for (int i = 0; i < 2; i++) mem_q[i] <= mem_nxt[i];
        end
    end

endmodule
